// File: rtl/rc_charge_cv_pkg.sv
// rc_cv_pkg: shared types and constants for the RC control-voltage generator
//   state_t     - update FSM states (IDLE, DIFF, MUL, APPLY)
//   Q_FRAC      - fraction bits of the Q16 coefficients
//   MUL_ITERS   - iterations of the serial multiplier
//   V_SAFE_*    - VCO safe output range
//   calc_alpha  - elaboration-time Q16 coefficient, clamped to [1, 65535]
package rc_cv_pkg;

    typedef enum logic [1:0] {IDLE, DIFF, MUL, APPLY} state_t;

    localparam int Q_FRAC     = 16;
    localparam int MUL_ITERS  = 16;
    localparam int V_SAFE_MIN = 1;
    localparam int V_SAFE_MAX = 32766;

    // c is capacitance scaled by 2^35, so 2^51 / (fs * R * C) lands in Q16
    function automatic logic [15:0] calc_alpha(longint unsigned sr, longint unsigned r, longint unsigned c);
        longint unsigned q;
        q = (64'd1 << 51) / (sr * r * c);
        return q < 64'd1 ? 16'd1 : q > 64'd65535 ? 16'hFFFF : q[15:0];
    endfunction

endpackage

// File: rtl/rc_charge_cv_serial_mul16.sv
// serial_mul16: 17x16 unsigned shift-add multiplier, one partial product per cycle
//   clk, I_RST   - clock, synchronous active-high reset
//   start        - loads a and b; iterations follow on the next MUL_ITERS edges
//   a, b         - 17-bit multiplicand, 16-bit multiplier
//   done         - high during the cycle whose edge performs the last iteration
//   product      - 33-bit result, final on the cycle after done
module serial_mul16
    import rc_cv_pkg::*;
(
    input  logic        clk,
    input  logic        I_RST,
    input  logic        start,
    input  logic [16:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [32:0] product
);

    logic [32:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;
    logic        run;

    assign done = run && cnt == 4'(MUL_ITERS - 1);

    always_ff @(posedge clk) begin
        if (I_RST) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            product <= '0;
        end else if (start) begin
            mcand   <= {16'b0, a};
            mplier  <= b;
            cnt     <= '0;
            run     <= 1'b1;
            product <= '0;
        end else if (run) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/rc_charge_cv.sv
// rc_charge_cv: first-order RC charge/discharge model producing the VCO control voltage
//   clk, I_RST    - clock, synchronous active-high reset
//   audio_clk_en  - sample strobe, starts one 19-cycle update
//   charge_en     - 1 charges toward V_HIGH, 0 discharges toward 0
//   v_control     - capacitor voltage (clamped to [1, 32766] when RC_CHARGE_CV_VCO_SAFE_EN is defined)
//   out_valid     - one-cycle pulse when v_control updates
//   busy          - update in progress
//   overrun       - sticky, strobe seen while busy
module rc_charge_cv
    import rc_cv_pkg::*;
#(
    parameter int SAMPLE_RATE  = 48000,
    parameter int R_CHARGE     = 100000,
    parameter int R_DISCHARGE  = 47000,
    parameter int C_35_SHIFTED = 1134,
    parameter int V_HIGH       = 16384,
    parameter int V_INIT       = 0
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic               charge_en,
    output logic signed [15:0] v_control,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [15:0] ALPHA_CHG = calc_alpha(64'(SAMPLE_RATE), 64'(R_CHARGE), 64'(C_35_SHIFTED));
    localparam logic [15:0] ALPHA_DIS = calc_alpha(64'(SAMPLE_RATE), 64'(R_DISCHARGE), 64'(C_35_SHIFTED));
    localparam logic [15:0] VH        = 16'(V_HIGH);

    state_t             state;
    logic [15:0]        v, target, alpha;
    logic [16:0]        mag, mag_c, step_raw, step;
    logic               neg, mul_done;
    logic signed [17:0] diff;
    logic signed [18:0] sum;
    logic [32:0]        product;

    always_comb begin
        diff     = $signed({2'b0, target}) - $signed({2'b0, v});
        mag_c    = diff[17] ? 17'(-diff) : diff[16:0];
        step_raw = 17'(product >> Q_FRAC);
        // a nonzero error always moves at least one LSB so the state converges exactly
        step     = (step_raw == '0 && mag != '0) ? 17'd1 : step_raw;
        sum      = neg ? $signed({3'b0, v}) - $signed({2'b0, step}) : $signed({3'b0, v}) + $signed({2'b0, step});
    end

    serial_mul16 u_mul (
        .clk     (clk),
        .I_RST   (I_RST),
        .start   (state == DIFF),
        .a       (mag_c),
        .b       (alpha),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state     <= IDLE;
            v         <= 16'(V_INIT);
            target    <= '0;
            alpha     <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (audio_clk_en && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (audio_clk_en) begin
                    target <= charge_en ? VH : '0;
                    alpha  <= charge_en ? ALPHA_CHG : ALPHA_DIS;
                    busy   <= 1'b1;
                    state  <= DIFF;
                end
                DIFF: begin
                    mag   <= mag_c;
                    neg   <= diff[17];
                    state <= MUL;
                end
                MUL: if (mul_done) state <= APPLY;
                APPLY: begin
                    v         <= sum[18] ? '0 : sum > $signed({3'b0, VH}) ? VH : sum[15:0];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RC_CHARGE_CV_VCO_SAFE_EN
    assign v_control = $signed(v < 16'(V_SAFE_MIN) ? 16'(V_SAFE_MIN) : v > 16'(V_SAFE_MAX) ? 16'(V_SAFE_MAX) : v);
`else
    assign v_control = $signed(v);
`endif

endmodule

// File: tb/tb_rc_charge_cv.sv
// tb_rc_charge_cv: randomized and directed bench for rc_charge_cv against a behavioural model
module tb_rc_charge_cv;

    logic               clk = 1'b0;
    logic               I_RST = 1'b1;
    logic               audio_clk_en = 1'b0;
    logic               charge_en = 1'b0;
    logic signed [15:0] v_control;
    logic               out_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

`ifdef RC_CHARGE_CV_VCO_SAFE_EN
    localparam int ZERO_OUT = 1;
`else
    localparam int ZERO_OUT = 0;
`endif

    always #5 clk = ~clk;

    rc_charge_cv dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .charge_en    (charge_en),
        .v_control    (v_control),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One exponential step: move toward the target by floor(|err| * alpha / 2^16), at least 1
    function automatic int next_v(int v, bit ch);
        int d, st;
        d  = (ch ? 16384 : 0) - v;
        st = ((d < 0 ? -d : d) * (ch ? 413 : 880)) >>> 16;
        if (st == 0 && d != 0) st = 1;
        v = d < 0 ? v - st : v + st;
        return v < 0 ? 0 : v > 16384 ? 16384 : v;
    endfunction

    function automatic int out_map(int v);
        return v < ZERO_OUT ? ZERO_OUT : v;
    endfunction

    int e = 0, acc = 0, m_v = 0, pend_v = 0;
    bit pend = 0, m_ov = 0, exp_valid = 0, started = 0;

    // Model: an accepted strobe at edge k produces its result at edge k+18; strobes in between are dropped
    always @(posedge clk) begin
        e++;
        exp_valid = 0;
        if (I_RST) begin
            m_v = 0; m_ov = 0; pend = 0; started = 1;
        end else begin
            if (audio_clk_en) begin
                if (pend) m_ov = 1;
                else begin
                    acc = e; pend = 1; pend_v = next_v(m_v, charge_en);
                end
            end
            if (pend && e == acc + 18) begin
                m_v = pend_v; pend = 0; exp_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, exp_valid);
            chk("busy", busy, pend);
            chk("overrun", overrun, m_ov);
            chk("v_control", v_control, out_map(m_v));
        end
    end

    task automatic pulse_strobe(int gap);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic strobe_wait(output int lat);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, prev, cnt, gap;
        repeat (3) @(negedge clk);
        I_RST = 1'b0;
        chk("rst_v", v_control, ZERO_OUT);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);

        charge_en = 1'b1;
        strobe_wait(lat);
        chk("lat_first", lat, 19);
        chk("first_step", v_control, 103);
        strobe_wait(lat);
        chk("second_step", v_control, 205);

        prev = v_control;
        for (int i = 0; i < 1600; i++) begin
            pulse_strobe(18 + $urandom_range(0, 3));
            chk("charge_mono", int'(v_control >= prev), 1);
            prev = v_control;
        end
        chk("charged", v_control, 16384);
        strobe_wait(lat);
        chk("lat_hold", lat, 19);
        chk("hold_top", v_control, 16384);

        charge_en = 1'b0;
        strobe_wait(lat);
        chk("first_dis", v_control, 16164);
        prev = v_control;
        for (int i = 0; i < 900; i++) begin
            pulse_strobe(18 + $urandom_range(0, 3));
            chk("dis_mono", int'(v_control <= prev), 1);
            prev = v_control;
        end
        chk("discharged", v_control, ZERO_OUT);

        charge_en = 1'b1;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (4) @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        chk("overrun_pulses", cnt, 1);
        chk("overrun_set", overrun, 1);
        chk("overrun_value", v_control, 103);
        strobe_wait(lat);
        chk("after_overrun", v_control, 205);
        chk("overrun_sticky", overrun, 1);

        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_in_mul", busy, 1);
        I_RST = 1'b1;
        @(negedge clk);
        I_RST = 1'b0;
        chk("abort_v", v_control, ZERO_OUT);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        chk("abort_no_pulse", cnt, 0);
        strobe_wait(lat);
        chk("lat_after_abort", lat, 19);
        chk("after_abort", v_control, 103);

        charge_en = 1'b1;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        charge_en = 1'b0;
        lat = 3;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("lat_toggle", lat, 19);
        chk("toggle_old_dir", v_control, 205);
        strobe_wait(lat);
        chk("toggle_new_dir", v_control, 203);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                I_RST = 1'b1;
                @(negedge clk);
                I_RST = 1'b0;
            end
            charge_en = 1'($urandom_range(0, 1));
            audio_clk_en = 1'b1;
            @(negedge clk);
            audio_clk_en = 1'b0;
            gap = $urandom_range(0, 24);
            repeat (gap) begin
                if ($urandom_range(0, 7) == 0) charge_en = ~charge_en;
                @(negedge clk);
            end
        end
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
